// File: rtl/pc_fetch_if.sv
// ============================================================================
// pc_fetch_if : fetch-stage bus bundle (control in, imem port, decode output)
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;

  // master: the fetch unit itself
  modport master (
    input  stall, redirect_valid, redirect_pc, exc_req, eret_req, epc,
    input  im_ready, im_rdata,
    output im_req, im_addr, if_valid, if_pc, if_instr, if_adel
  );

  // slave: memory, hazard unit, decode and CP0 side
  modport slave (
    output stall, redirect_valid, redirect_pc, exc_req, eret_req, epc,
    output im_ready, im_rdata,
    input  im_req, im_addr, if_valid, if_pc, if_instr, if_adel
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// pc_fetch : instruction-fetch front end with delay-slot redirect and skid
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_1000
) (
  input  wire logic   clk_i,
  input  wire logic   reset_i,
  pc_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DISCARD = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_adel_q, if_adel_d;

  logic        legal;
  logic        req;
  logic        complete;
  logic        flush;
  logic [31:0] req_addr;

  assign legal = (pc_q[1:0] == 2'b00) && (pc_q >= IM_BASE) && ({1'b0, pc_q} < IM_END);
  assign flush = bus.exc_req | bus.eret_req;

  // Outstanding requests keep their own address so a flush can retarget pc
  assign req_addr = (state_q == S_BUSY || state_q == S_DISCARD) ? addr_q : pc_q;

  always_comb begin
    req = 1'b0;
    case (state_q)
      S_IDLE:    req = !bus.stall && legal && !skid_v_q;
      S_BUSY:    req = 1'b1;
      S_DISCARD: req = 1'b1;
      default:   req = 1'b0;
    endcase
  end

  assign complete    = req && bus.im_ready && (state_q != S_DISCARD);
  assign bus.im_req  = req & ~reset_i;
  assign bus.im_addr = req_addr;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = (state_q == S_IDLE) ? pc_q : addr_q;
    pend_d       = pend_q;
    tgt_d        = tgt_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_adel_d    = if_adel_q;

    if (flush) begin
      pc_d       = bus.exc_req ? EXC_VEC : bus.epc;
      if_valid_d = 1'b0;
      skid_v_d   = 1'b0;
      pend_d     = 1'b0;
      state_d    = (req && !bus.im_ready) ? S_DISCARD : S_IDLE;
    end else begin
      if (bus.redirect_valid && state_q != S_ERR) begin
        pend_d = 1'b1;
        tgt_d  = bus.redirect_pc;
      end

      if (complete) begin
        // A redirect arriving with a completion makes that word the delay slot
        pc_d    = bus.redirect_valid ? bus.redirect_pc : (pend_q ? tgt_q : pc_q + 32'd4);
        pend_d  = 1'b0;
        state_d = S_IDLE;
        if (bus.stall) begin
          skid_v_d     = 1'b1;
          skid_pc_d    = req_addr;
          skid_instr_d = bus.im_rdata;
        end else begin
          if_valid_d = 1'b1;
          if_pc_d    = req_addr;
          if_instr_d = bus.im_rdata;
          if_adel_d  = 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req) state_d = S_BUSY;
            if (!bus.stall) begin
              if (skid_v_q) begin
                if_valid_d = 1'b1;
                if_pc_d    = skid_pc_q;
                if_instr_d = skid_instr_q;
                if_adel_d  = 1'b0;
                skid_v_d   = 1'b0;
              end else if (!legal) begin
                if_valid_d = 1'b1;
                if_pc_d    = pc_q;
                if_instr_d = 32'd0;
                if_adel_d  = 1'b1;
                state_d    = S_ERR;
              end else begin
                if_valid_d = 1'b0;
              end
            end
          end
          S_DISCARD: begin
            if (bus.im_ready) state_d = S_IDLE;
            if (!bus.stall) if_valid_d = 1'b0;
          end
          default: begin
            if (!bus.stall) if_valid_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      pend_q       <= 1'b0;
      tgt_q        <= 32'd0;
      skid_v_q     <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= RESET_PC;
      if_instr_q   <= 32'd0;
      if_adel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      tgt_q        <= tgt_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_adel_q    <= if_adel_d;
    end
  end

  assign bus.if_valid = if_valid_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_adel  = if_adel_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// tb_pc_fetch : directed scenarios plus randomized run against a fetch-stream model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_if bus ();

  pc_fetch #(
    .RESET_PC (32'h0000_3000),
    .EXC_VEC  (32'h0000_4180),
    .IM_BASE  (32'h0000_3000),
    .IM_SIZE  (32'h0000_1000)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F96;
  endfunction

  assign bus.im_rdata = mem_word(bus.im_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic adel);
    chk({tag, "_valid"}, {31'd0, bus.if_valid}, {31'd0, v});
    chk({tag, "_pc"}, bus.if_pc, pc);
    if (v) begin
      chk({tag, "_adel"}, {31'd0, bus.if_adel}, {31'd0, adel});
      chk({tag, "_instr"}, bus.if_instr, adel ? 32'd0 : mem_word(pc));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference state for the random run
  logic [31:0] exp_fetch;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic [31:0] q_pc[$];
  logic        prev_stall, prev_req, prev_ready;
  logic [31:0] prev_addr, prev_pc, prev_instr;
  logic        prev_valid;
  int          quiet;
  int          delivered;
  logic        r;
  logic [31:0] rt;

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
    bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.epc = 32'd0; bus.im_ready = 1'b1;
    repeat (2) cyc();
    chk_out("rst", 1'b0, 32'h3000, 1'b0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_req", {31'd0, bus.im_req}, 32'd0);

    // Zero-latency sequential fetch
    rst = 1'b0; #2;
    chk("seq_addr0", bus.im_addr, 32'h3000);
    chk("seq_req0", {31'd0, bus.im_req}, 32'd1);
    cyc(); chk_out("seq0", 1'b1, 32'h3000, 1'b0); chk("seq_addr1", bus.im_addr, 32'h3004);
    cyc(); chk_out("seq1", 1'b1, 32'h3004, 1'b0); chk("seq_addr2", bus.im_addr, 32'h3008);
    cyc(); chk_out("seq2", 1'b1, 32'h3008, 1'b0); chk("seq_addr3", bus.im_addr, 32'h300C);

    // Branch with the delay slot in flight for two wait cycles
    bus.im_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3100;
    cyc(); bus.redirect_valid = 1'b0;
    chk("br_bub1", {31'd0, bus.if_valid}, 32'd0); chk("br_addr1", bus.im_addr, 32'h300C);
    cyc(); chk("br_addr2", bus.im_addr, 32'h300C);
    bus.im_ready = 1'b1;
    cyc(); chk_out("br_slot", 1'b1, 32'h300C, 1'b0); chk("br_tgt_addr", bus.im_addr, 32'h3100);
    cyc(); chk_out("br_tgt", 1'b1, 32'h3100, 1'b0); chk("br_next_addr", bus.im_addr, 32'h3104);

    // Response lands in the skid while stalled
    bus.im_ready = 1'b0;
    cyc(); bus.stall = 1'b1; bus.im_ready = 1'b1; #2;
    chk("sk_busy_req", {31'd0, bus.im_req}, 32'd1);
    cyc(); chk_out("sk_hold1", 1'b0, 32'h3100, 1'b0);
    chk("sk_stall_req", {31'd0, bus.im_req}, 32'd0);
    cyc(); chk_out("sk_hold2", 1'b0, 32'h3100, 1'b0);
    bus.stall = 1'b0; #2;
    chk("sk_drain_req", {31'd0, bus.im_req}, 32'd0);
    cyc(); chk_out("sk_out", 1'b1, 32'h3104, 1'b0); chk("sk_next_addr", bus.im_addr, 32'h3108);

    // Exception while BUSY at 0x3020
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3020;
    cyc(); bus.redirect_valid = 1'b0; bus.im_ready = 1'b0;
    chk_out("ex_slot", 1'b1, 32'h3108, 1'b0); chk("ex_addr", bus.im_addr, 32'h3020);
    cyc(); bus.exc_req = 1'b1;
    cyc(); bus.exc_req = 1'b0;
    chk("ex_flush_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("ex_disc_addr1", bus.im_addr, 32'h3020); chk("ex_disc_req", {31'd0, bus.im_req}, 32'd1);
    cyc(); chk("ex_disc_addr2", bus.im_addr, 32'h3020);
    bus.im_ready = 1'b1;
    cyc(); chk("ex_vec_req", {31'd0, bus.im_req}, 32'd0);
    cyc(); chk_out("ex_vec", 1'b1, 32'h4180, 1'b1);
    bus.stall = 1'b1;
    cyc(); chk_out("err_hold", 1'b1, 32'h4180, 1'b1);
    bus.stall = 1'b0;
    cyc(); chk("err_drop", {31'd0, bus.if_valid}, 32'd0); chk("err_req", {31'd0, bus.im_req}, 32'd0);

    // ERET, then a misaligned branch target after its delay slot
    bus.eret_req = 1'b1; bus.epc = 32'h3200;
    cyc(); bus.eret_req = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3002; #2;
    chk("er_addr", bus.im_addr, 32'h3200); chk("er_req", {31'd0, bus.im_req}, 32'd1);
    cyc(); bus.redirect_valid = 1'b0; #2;
    chk_out("al_slot", 1'b1, 32'h3200, 1'b0); chk("al_req0", {31'd0, bus.im_req}, 32'd0);
    cyc(); chk_out("al_adel", 1'b1, 32'h3002, 1'b1); chk("al_req1", {31'd0, bus.im_req}, 32'd0);
    cyc(); chk("al_req2", {31'd0, bus.im_req}, 32'd0);
    bus.eret_req = 1'b1; bus.epc = 32'h3010;
    cyc(); bus.eret_req = 1'b0; #2;
    chk("er2_addr", bus.im_addr, 32'h3010);
    cyc(); chk_out("er2_out", 1'b1, 32'h3010, 1'b0);

    // Asynchronous reset in the middle of a BUSY fetch
    bus.im_ready = 1'b0;
    cyc(); #1; rst = 1'b1; #1;
    chk("ar_pc", bus.if_pc, 32'h3000);
    chk("ar_instr", bus.if_instr, 32'd0);
    chk("ar_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("ar_req", {31'd0, bus.im_req}, 32'd0);
    cyc(); cyc();

    // Randomized run checked against the architectural fetch stream
    rst = 1'b0; #1;
    chk("rr_addr0", bus.im_addr, 32'h3000);
    exp_fetch = 32'h3000; m_pend = 1'b0; m_tgt = 32'd0;
    prev_stall = 1'b0; prev_req = 1'b0; prev_ready = 1'b0; prev_addr = 32'd0;
    prev_valid = 1'b0; prev_pc = 32'd0; prev_instr = 32'd0;
    quiet = 0; delivered = 0;
    for (int i = 0; i < 600; i++) begin
      if (i < 590) begin
        bus.stall    = ($urandom % 4) == 0;
        bus.im_ready = ($urandom % 3) != 0;
        r            = ($urandom % 8) == 0;
        if (!m_pend && exp_fetch >= 32'h3E00) r = 1'b1;
      end else begin
        bus.stall = 1'b0; bus.im_ready = 1'b1; r = 1'b0;
      end
      rt = 32'h3000 + ($urandom_range(0, 960) << 2);
      bus.redirect_valid = r;
      bus.redirect_pc    = rt;
      @(negedge clk);
      if (prev_stall) begin
        chk("rr_hold_valid", {31'd0, bus.if_valid}, {31'd0, prev_valid});
        chk("rr_hold_pc", bus.if_pc, prev_pc);
        chk("rr_hold_instr", bus.if_instr, prev_instr);
      end else if (bus.if_valid) begin
        chk("rr_have_item", {31'd0, q_pc.size() != 0}, 32'd1);
        if (q_pc.size() != 0) begin
          chk("rr_out_pc", bus.if_pc, q_pc[0]);
          chk("rr_out_instr", bus.if_instr, mem_word(q_pc[0]));
          void'(q_pc.pop_front());
        end
        chk("rr_out_adel", {31'd0, bus.if_adel}, 32'd0);
        delivered++;
        quiet = 0;
      end
      if (prev_req && !prev_ready) begin
        chk("rr_req_held", {31'd0, bus.im_req}, 32'd1);
        chk("rr_addr_held", bus.im_addr, prev_addr);
      end
      if (bus.im_req && bus.im_ready) begin
        chk("rr_fetch_addr", bus.im_addr, exp_fetch);
        q_pc.push_back(exp_fetch);
        exp_fetch = r ? rt : (m_pend ? m_tgt : exp_fetch + 32'd4);
        m_pend = 1'b0;
      end else if (r) begin
        m_pend = 1'b1;
        m_tgt  = rt;
      end
      quiet++;
      if (quiet > 64) begin
        chk("rr_liveness", 32'd0, 32'd1);
        break;
      end
      prev_stall = bus.stall; prev_req = bus.im_req; prev_ready = bus.im_ready;
      prev_addr = bus.im_addr; prev_valid = bus.if_valid;
      prev_pc = bus.if_pc; prev_instr = bus.if_instr;
      @(posedge clk); #1;
    end
    chk("rr_backlog", {31'd0, q_pc.size() <= 1}, 32'd1);
    chk("rr_progress", {31'd0, delivered > 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch front end: owns the architectural PC, issues word reads to instruction memory, and delivers the fetched instruction to the decode stage.
- Consumes the next-PC redirect produced in decode, honouring the one-instruction branch delay slot.
- Also takes exception and ERET redirects from the CP0/exception logic, and stall from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_SIZE, 32'h0000_1000, instruction memory size in bytes.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode cannot accept; if_* outputs must hold.
- redirect_valid  in  1  taken branch/jump resolved in decode (target applies after the delay slot).
- redirect_pc  in  32  branch/jump target.
- exc_req  in  1  exception flush; highest priority after reset.
- eret_req  in  1  return from exception.
- epc  in  32  ERET target.
- im_req  out  1  memory read request.
- im_addr  out  32  word address of the request (= pc).
- im_ready  in  1  response valid this cycle; im_rdata valid when high.
- im_rdata  in  32  instruction word.
- if_valid  out  1  if_instr/if_pc hold a live instruction.
- if_pc  out  32  PC of the delivered instruction.
- if_instr  out  32  delivered instruction.
- if_adel  out  1  delivered slot is an address-error fetch.

Behaviour:
- Reset, asynchronous: pc=RESET_PC; if_valid=0, if_instr=0, if_pc=RESET_PC, if_adel=0, im_req=0; skid empty; pending redirect cleared; state IDLE.
- pc is legal when pc[1:0]==0 and IM_BASE <= pc < IM_BASE+IM_SIZE.
- Memory protocol:
  - Once im_req is raised, im_req and im_addr stay stable until the cycle im_ready=1.
  - Data is sampled in that same cycle, so the minimum latency is 0 wait cycles.
- States:
  - IDLE: im_req=stall?0:(legal && skid empty). On a request with im_ready=1 the fetch completes in that cycle; with im_ready=0 go to BUSY. An illegal pc with !stall loads the output with if_valid=1, if_adel=1, if_instr=0, if_pc=pc, then goes to ERR.
  - BUSY: im_req=1 held. On im_ready, complete and go to IDLE.
  - DISCARD: im_req=1 held at the old address. On im_ready, drop the data and go to IDLE.
  - ERR: im_req=0; the output holds until !stall, then if_valid=0. Leave ERR only on exc_req or eret_req.
- Completion:
  - If !stall, load if_valid=1, if_pc=im_addr, if_instr=im_rdata, if_adel=0 on the next edge.
  - If stall, store the word in a one-entry skid buffer instead.
  - In the first cycle with !stall and the skid full, the skid moves to the output; no new request is issued that cycle.
  - If !stall and nothing is delivered, if_valid=0 on the next edge (bubble).
- PC update on completion: pc <= pending ? pending_target : pc+4, and pending is cleared. 32-bit wrap on pc+4 is permitted; the result is illegal and leads to ERR.
- Redirect and delay slot:
  - redirect_valid=1 (any state except ERR) sets pending=1 and pending_target=redirect_pc.
  - A later assertion overwrites the target.
  - If redirect_valid and a completion occur in the same cycle, that completion is the delay slot and pc <= redirect_pc directly.
  - A redirect never flushes the output register or the in-flight fetch.
- exc_req / eret_req (exc wins if both are asserted):
  - Next edge: pc=EXC_VEC (or epc), if_valid=0, skid emptied, pending cleared.
  - State becomes DISCARD if a request is outstanding, else IDLE.
  - Flush overrides stall.
  - A flush during DISCARD only retargets pc.
- Stall has no effect on pc except through the completion rules above.

Test Plan:
- Reset release, im_ready tied 1, no stall → if_pc 0x3000, 0x3004, 0x3008 on consecutive cycles with if_valid=1; im_addr leads if_pc by one cycle.
- Branch at 0x3008 raises redirect_valid with target 0x3100 while 0x300C is in flight with 2 wait cycles → 0x300C is delivered (delay slot), then 0x3100; 0x3010 never appears on im_addr.
- Stall asserted while BUSY, response arrives during the stall → if_* holds its old value; when stall drops the skid word is delivered, and im_req stays low for that one cycle.
- exc_req while BUSY at 0x3020 → if_valid=0 next cycle; im_addr stays 0x3020 until im_ready and that data is dropped; next delivered if_pc=0x4180.
- redirect_pc=0x3002 → after the delay slot, output shows if_pc=0x3002, if_adel=1, if_instr=0, and im_req stays 0; eret_req with epc=0x3010 → fetch resumes and delivers 0x3010.
- Async reset asserted mid-BUSY → all outputs return to reset values immediately without waiting for a clock; pc=0x3000 after release.
